// File: rtl/root_5_en_iter.sv
// root_5_en_iter: iterative floor fifth root of a 5*w-bit unsigned operand.
// The result is resolved one bit at a time, MSB first. For each bit, the
// trial value t = root | (1 << bit) is raised to the fifth power with one
// shared multiplier, then compared against the operand.
// Each bit takes 5 enabled cycles: SQ, MUL x3, CMP.
// clk_en low freezes every register, including the handshake outputs.
// Optional feature macro: ROOT_5_REM_EN adds a remainder output
// rem = x - res^5.
module root_5_en_iter #(
    parameter int w = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             x_vld,
    output logic             x_rdy,
    input  logic [5*w-1:0]   x,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic [w-1:0]     res
`ifdef ROOT_5_REM_EN
    ,
    output logic [5*w-1:0]   rem
`endif
);

    localparam int XW = 5 * w;
    localparam int BW = (w > 1) ? $clog2(w) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SQ,
        MUL,
        CMP,
        DONE
    } state_t;

    state_t          state;
    logic [XW-1:0]   x_q;
    logic [XW-1:0]   acc;
    logic [w-1:0]    root;
    logic [BW-1:0]   bit_cnt;
    logic [1:0]      mcnt;
`ifdef ROOT_5_REM_EN
    logic [XW-1:0]   pow;
`endif

    logic [w-1:0]    t;
    logic [XW-1:0]   mul_a;
    logic [XW-1:0]   mul_b;
    logic [XW-1:0]   prod;
    logic            keep;

    // Trial value, shared multiplier (t*t in SQ, acc*t in MUL) and trial compare.
    always_comb begin
        t     = root | (w'(1) << bit_cnt);
        mul_a = (state == SQ) ? {{(XW-w){1'b0}}, t} : acc;
        mul_b = {{(XW-w){1'b0}}, t};
        prod  = mul_a * mul_b;
        keep  = (acc <= x_q);
    end

    // Control FSM plus datapath registers; everything holds while clk_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            x_rdy   <= 1'b1;
            res_vld <= 1'b0;
            res     <= '0;
            x_q     <= '0;
            acc     <= '0;
            root    <= '0;
            bit_cnt <= '0;
            mcnt    <= '0;
`ifdef ROOT_5_REM_EN
            pow     <= '0;
            rem     <= '0;
`endif
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (x_vld) begin
                        x_q     <= x;
                        root    <= '0;
                        bit_cnt <= BW'(w - 1);
                        x_rdy   <= 1'b0;
`ifdef ROOT_5_REM_EN
                        pow     <= '0;
`endif
                        state   <= SQ;
                    end
                end
                SQ: begin
                    acc   <= prod;
                    mcnt  <= '0;
                    state <= MUL;
                end
                MUL: begin
                    acc  <= prod;
                    mcnt <= mcnt + 2'd1;
                    if (mcnt == 2'd2) begin
                        state <= CMP;
                    end
                end
                CMP: begin
                    if (keep) begin
                        root <= t;
`ifdef ROOT_5_REM_EN
                        pow  <= acc;
`endif
                    end
                    if (bit_cnt == '0) begin
                        // Final bit: use the just-decided root/power, not the stale registers.
                        res     <= keep ? t : root;
`ifdef ROOT_5_REM_EN
                        rem     <= x_q - (keep ? acc : pow);
`endif
                        res_vld <= 1'b1;
                        state   <= DONE;
                    end else begin
                        bit_cnt <= bit_cnt - BW'(1);
                        state   <= SQ;
                    end
                end
                DONE: begin
                    if (res_rdy) begin
                        res_vld <= 1'b0;
                        x_rdy   <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_root_5_en_iter.sv
// Testbench for root_5_en_iter (w=8).
// It applies a table of known vectors, then randomized operands checked
// against an arithmetic fifth-root model, then hand-written sequences for
// clk_en gating, result back-pressure and mid-operation reset.
module tb_root_5_en_iter;

    localparam int W  = 8;
    localparam int XW = 5 * W;

    logic          clk;
    logic          rst_n;
    logic          clk_en;
    logic          x_vld;
    logic          x_rdy;
    logic [XW-1:0] x;
    logic          res_vld;
    logic          res_rdy;
    logic [W-1:0]  res;
`ifdef ROOT_5_REM_EN
    logic [XW-1:0] rem;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    root_5_en_iter #(.w(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_en  (clk_en),
        .x_vld   (x_vld),
        .x_rdy   (x_rdy),
        .x       (x),
        .res_vld (res_vld),
        .res_rdy (res_rdy),
        .res     (res)
`ifdef ROOT_5_REM_EN
        ,
        .rem     (rem)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XW-1:0] xv;
        logic [W-1:0]  exp_res;
        logic [XW-1:0] exp_rem;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Reference model: the largest r in [0, 2^W) with r^5 <= x, found by brute force.
    function automatic logic [W-1:0] ref_root(input logic [XW-1:0] xv);
        logic [W-1:0]    r;
        longint unsigned c;
        r = '0;
        for (int unsigned i = 0; i < (1 << W); i++) begin
            c = longint'(i);
            if (c * c * c * c * c <= longint'(xv)) r = i[W-1:0];
        end
        return r;
    endfunction

    function automatic logic [XW-1:0] ref_rem(input logic [XW-1:0] xv);
        longint unsigned c;
        c = longint'(ref_root(xv));
        return xv - XW'(c * c * c * c * c);
    endfunction

    // Runs one operation, starting and ending at a negedge. In toggle mode,
    // clk_en alternates and junk x_vld pulses are driven while the DUT is busy.
    task automatic run_op(input logic [XW-1:0] xv, input bit toggle, input int hold,
                          output logic [W-1:0] got_res, output logic [XW-1:0] got_rem,
                          output int en_edges, output int clocks);
        int   guard;
        bit   busy_ok;
        bit   stable;
        guard = 0;
        while (!x_rdy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("x_rdy_before_accept", x_rdy, 1);
        x      = xv;
        x_vld  = 1'b1;
        clk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        x_vld    = 1'b0;
        en_edges = 0;
        clocks   = 0;
        busy_ok  = 1'b1;
        while (!res_vld && clocks < 1000) begin
            if (x_rdy) busy_ok = 1'b0;
            clk_en = toggle ? (clocks % 2 == 1) : 1'b1;
            if (toggle) begin
                x_vld = 1'b1;
                x     = {8'h00, 32'($urandom)};
            end
            @(posedge clk);
            clocks++;
            if (clk_en) en_edges++;
            @(negedge clk);
        end
        x_vld  = 1'b0;
        clk_en = 1'b1;
        check("x_rdy_low_while_busy", busy_ok, 1);
        check("res_vld_timeout", res_vld, 1);
        got_res = res;
`ifdef ROOT_5_REM_EN
        got_rem = rem;
`else
        got_rem = '0;
`endif
        if (hold > 0) begin
            stable = 1'b1;
            repeat (hold) begin
                @(posedge clk);
                @(negedge clk);
                if (res_vld !== 1'b1 || res !== got_res || x_rdy !== 1'b0) stable = 1'b0;
            end
            check("hold_res_stable", stable, 1);
        end
        res_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_rdy = 1'b0;
        check("x_rdy_after_consume", x_rdy, 1);
        check("res_vld_after_consume", res_vld, 0);
    endtask

    vec_t          vecs[8];
    logic [W-1:0]  r_res;
    logic [XW-1:0] r_rem;
    logic [XW-1:0] xr;
    logic [W-1:0]  rr;
    int            en_e;
    int            clks;
    longint unsigned p5;

    initial begin
        rst_n   = 1'b0;
        clk_en  = 1'b1;
        x_vld   = 1'b0;
        x       = '0;
        res_rdy = 1'b0;

        vecs[0] = '{40'd0,             8'd0,   40'd0};
        vecs[1] = '{40'd243,           8'd3,   40'd0};
        vecs[2] = '{40'd242,           8'd2,   40'd210};
        vecs[3] = '{40'hFF_FFFF_FFFF,  8'd255, 40'd21307718400};
        vecs[4] = '{40'd32,            8'd2,   40'd0};
        vecs[5] = '{40'd1,             8'd1,   40'd0};
        vecs[6] = '{40'd3125,          8'd5,   40'd0};
        vecs[7] = '{40'd1024,          8'd4,   40'd0};

        repeat (3) @(negedge clk);
        check("reset_x_rdy", x_rdy, 1);
        check("reset_res_vld", res_vld, 0);
        check("reset_res", res, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table of known vectors with full-rate enable.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].xv, 1'b0, 0, r_res, r_rem, en_e, clks);
            check($sformatf("vec%0d_res", i), r_res, vecs[i].exp_res);
            check($sformatf("vec%0d_latency", i), en_e, 40);
`ifdef ROOT_5_REM_EN
            check($sformatf("vec%0d_rem", i), r_rem, vecs[i].exp_rem);
`endif
        end

        // Randomized operands: fully random values, plus exact powers and their neighbours.
        for (int i = 0; i < 24; i++) begin
            if (i % 3 == 0) begin
                xr = {8'($urandom), 32'($urandom)};
            end else begin
                rr = 8'($urandom_range(1, 255));
                p5 = longint'(rr);
                p5 = p5 * p5 * p5 * p5 * p5;
                xr = (i % 3 == 1) ? XW'(p5) : XW'(p5 - 1);
            end
            run_op(xr, 1'b0, 0, r_res, r_rem, en_e, clks);
            check($sformatf("rand%0d_res x=%0d", i, xr), r_res, ref_root(xr));
`ifdef ROOT_5_REM_EN
            check($sformatf("rand%0d_rem x=%0d", i, xr), r_rem, ref_rem(xr));
`endif
        end

        // clk_en toggling every cycle, with junk x_vld pulses while busy.
        run_op(40'd32, 1'b1, 0, r_res, r_rem, en_e, clks);
        check("toggle_res", r_res, 2);
        check("toggle_enabled_edges", en_e, 40);
        check("toggle_clocks", clks, 80);

        // Back-pressure: res_rdy held low 10 cycles, then a back-to-back operation.
        run_op(40'd243, 1'b0, 10, r_res, r_rem, en_e, clks);
        check("hold_res", r_res, 3);
        run_op(40'd1, 1'b0, 0, r_res, r_rem, en_e, clks);
        check("b2b_res", r_res, 1);

        // Reset in the middle of an operation: outputs return to reset values at once.
        x      = 40'd1024;
        x_vld  = 1'b1;
        clk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        x_vld = 1'b0;
        repeat (16) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_res_vld", res_vld, 0);
        check("midrst_x_rdy", x_rdy, 1);
        check("midrst_res", res, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_res_vld", res_vld, 0);
        run_op(40'd3125, 1'b0, 0, r_res, r_rem, en_e, clks);
        check("postrst_res", r_res, 5);
        check("postrst_latency", en_e, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
